tour_cmd_sequencer: RTL and testbench

TOUR_CMD_SEQUENCER -- requirements
Module: tour_cmd_sequencer

---
 rtl/tour_cmd_sequencer_if.sv | 35 +++
 rtl/tour_cmd_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_tour_cmd_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tour_cmd_sequencer_if.sv
// Bus bundle between the command host/RemoteComm side (master) and the
// tour command sequencer (slave). Counter widths follow the queue DEPTH.
interface tour_cmd_sequencer_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic          ld_cmd;
    logic [15:0]   ld_data;
    logic          full;
    logic          start;
    logic          abort;
    logic [15:0]   cmd;
    logic          snd_cmd;
    logic          cmd_snt;
    logic          resp_rdy;
    logic [7:0]    resp;
    logic          busy;
    logic          done;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic          tmo;
    logic [AW-1:0] fail_idx;

    modport master (
        output ld_cmd, ld_data, start, abort, cmd_snt, resp_rdy, resp,
        input  full, cmd, snd_cmd, busy, done, pass_cnt, fail_cnt, tmo, fail_idx
    );

    modport slave (
        input  ld_cmd, ld_data, start, abort, cmd_snt, resp_rdy, resp,
        output full, cmd, snd_cmd, busy, done, pass_cnt, fail_cnt, tmo, fail_idx
    );
endinterface

// File: rtl/tour_cmd_sequencer.sv
// Queues 16-bit commands, issues them one at a time to RemoteComm and scores replies.
// Optional build macro SEQ_STOP_ON_FAIL_EN: end the run at the first failing command.
module tour_cmd_sequencer #(
    parameter int         DEPTH      = 8,
    parameter int         TMO_CYCLES = 10000000,
    parameter logic [7:0] EXP_RESP   = 8'hA5
) (
    input  logic                clk,
    input  logic                rst_n,
    tour_cmd_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_SNT, WAIT_RESP, NEXT, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          snd_q, snd_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          ok_q, ok_d;
    logic [CW-1:0] pass_q, pass_d;
    logic [CW-1:0] fail_q, fail_d;
    logic          tmo_q, tmo_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] pos_q, pos_d;
    logic          full;
    logic          busy;
    logic          wr_en;

    assign full = (count_q == DEPTH_C);
    assign busy = (state_q == SEND) || (state_q == WAIT_SNT) ||
                  (state_q == WAIT_RESP) || (state_q == NEXT);
    assign wr_en = bus.ld_cmd && !full && !busy && !bus.abort;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cmd_d    = cmd_q;
        snd_d    = 1'b0;
        tmr_d    = tmr_q;
        ok_d     = ok_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        tmo_d    = tmo_q;
        idx_d    = idx_q;
        pos_d    = pos_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CW'(1);
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    pass_d  = '0;
                    fail_d  = '0;
                    tmo_d   = 1'b0;
                    idx_d   = '0;
                    pos_d   = '0;
                    state_d = (count_q != '0) ? SEND : DONE;
                end
            end
            SEND: begin
                cmd_d   = mem_q[rd_ptr_q];
                snd_d   = 1'b1;
                tmr_d   = '0;
                state_d = WAIT_SNT;
            end
            WAIT_SNT: begin
                tmr_d = tmr_q + TW'(1);
                if (bus.cmd_snt) begin
                    state_d = WAIT_RESP;
                end else if (tmr_q >= TMO_LAST) begin
                    ok_d    = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = NEXT;
                end
            end
            WAIT_RESP: begin
                tmr_d = tmr_q + TW'(1);
                // A reply landing on the expiry cycle still counts as a reply.
                if (bus.resp_rdy) begin
                    ok_d    = (bus.resp == EXP_RESP);
                    state_d = NEXT;
                end else if (tmr_q >= TMO_LAST) begin
                    ok_d    = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - CW'(1);
                pos_d    = pos_q + AW'(1);
                if (ok_q) begin
                    pass_d = pass_q + CW'(1);
                end else begin
                    fail_d = fail_q + CW'(1);
                    if (fail_q == '0) begin
                        idx_d = pos_q;
                    end
                end
                state_d = (count_q == CW'(1)) ? DONE : SEND;
`ifdef SEQ_STOP_ON_FAIL_EN
                if (!ok_q) begin
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                    count_d  = '0;
                    state_d  = DONE;
                end
`else
`endif
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything: flush the queue, keep the scoreboard as-is.
        if (bus.abort) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            cmd_d    = cmd_q;
            snd_d    = 1'b0;
            pass_d   = pass_q;
            fail_d   = fail_q;
            tmo_d    = tmo_q;
            idx_d    = idx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cmd_q    <= 16'h0000;
            snd_q    <= 1'b0;
            tmr_q    <= '0;
            ok_q     <= 1'b0;
            pass_q   <= '0;
            fail_q   <= '0;
            tmo_q    <= 1'b0;
            idx_q    <= '0;
            pos_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cmd_q    <= cmd_d;
            snd_q    <= snd_d;
            tmr_q    <= tmr_d;
            ok_q     <= ok_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            tmo_q    <= tmo_d;
            idx_q    <= idx_d;
            pos_q    <= pos_d;
        end
    end

    // Queue storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= bus.ld_data;
        end
    end

    assign bus.full     = full;
    assign bus.busy     = busy;
    assign bus.done     = (state_q == DONE);
    assign bus.cmd      = cmd_q;
    assign bus.snd_cmd  = snd_q;
    assign bus.pass_cnt = pass_q;
    assign bus.fail_cnt = fail_q;
    assign bus.tmo      = tmo_q;
    assign bus.fail_idx = idx_q;
endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed bench for tour_cmd_sequencer: table of run scenarios plus hand-written
// sequences for queue full/drop, abort and mid-run reset.
module tb_tour_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tour_cmd_sequencer_if #(.DEPTH(DEPTH)) bus ();

    tour_cmd_sequencer #(
        .DEPTH(DEPTH), .TMO_CYCLES(TMO), .EXP_RESP(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    // mode per command: 0 = normal reply, 1 = cmd_snt never comes, 2 = reply on expiry cycle
    typedef struct packed {
        int              n;
        logic [3:0][15:0] c;
        logic [3:0][1:0]  mode;
        logic [3:0][7:0]  r;
        int              e_pass;
        int              e_fail;
        int              e_idx;
        int              e_tmo;
        int              e_iss;
    } vec_t;

    vec_t vecs [5];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(input int n, input logic [63:0] c, input logic [7:0] m,
                                input logic [31:0] r, input int p, input int f,
                                input int i, input int t, input int iss);
        vec_t v;
        v.n = n; v.c = c; v.mode = m; v.r = r;
        v.e_pass = p; v.e_fail = f; v.e_idx = i; v.e_tmo = t; v.e_iss = iss;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] w);
        bus.ld_cmd  = 1'b1;
        bus.ld_data = w;
        step();
        bus.ld_cmd  = 1'b0;
    endtask

    task automatic start_run();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("lat_snd_early", 32'(bus.snd_cmd), 32'd0);
        check("busy_on", 32'(bus.busy), 32'd1);
        check("done_clr", 32'(bus.done), 32'd0);
        step();
        check("lat_snd", 32'(bus.snd_cmd), 32'd1);
    endtask

    task automatic wait_event(output bit got);
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (bus.snd_cmd) begin
                got = 1'b1;
                return;
            end
            if (bus.done) return;
            step();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_event: got no snd_cmd/done, expected one within 300 cycles");
    endtask

    task automatic wait_done();
        for (int k = 0; k < 300; k++) begin
            if (bus.done) return;
            step();
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_done: got done=0, expected done=1 within 300 cycles");
    endtask

    // Entered in the cycle where snd_cmd is high (cycle 0 of the command).
    task automatic respond(input logic [1:0] mode, input logic [7:0] b);
        case (mode)
            2'd0: begin
                step();
                check("snd_pulse", 32'(bus.snd_cmd), 32'd0);
                bus.cmd_snt = 1'b1;
                step();
                bus.cmd_snt  = 1'b0;
                bus.resp_rdy = 1'b1;
                bus.resp     = b;
                step();
                bus.resp_rdy = 1'b0;
            end
            2'd1: begin
                for (int k = 0; k < TMO - 1; k++) step();
                check("tmo_before", 32'(bus.tmo), 32'd0);
                check("busy_wait", 32'(bus.busy), 32'd1);
                step();
                check("tmo_expire", 32'(bus.tmo), 32'd1);
            end
            default: begin
                bus.cmd_snt = 1'b1;
                step();
                bus.cmd_snt = 1'b0;
                for (int k = 1; k < TMO - 1; k++) step();
                bus.resp_rdy = 1'b1;
                bus.resp     = b;
                step();
                bus.resp_rdy = 1'b0;
                check("tmo_edge", 32'(bus.tmo), 32'd0);
            end
        endcase
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_full"}, 32'(bus.full), 32'd0);
        check({tag, "_cmd"}, 32'(bus.cmd), 32'd0);
        check({tag, "_snd"}, 32'(bus.snd_cmd), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_tmo"}, 32'(bus.tmo), 32'd0);
        check({tag, "_pass"}, 32'(bus.pass_cnt), 32'd0);
        check({tag, "_fail"}, 32'(bus.fail_cnt), 32'd0);
        check({tag, "_idx"}, 32'(bus.fail_idx), 32'd0);
    endtask

    initial begin
        bit got;
        int iss;

        bus.ld_cmd = 1'b0; bus.ld_data = '0; bus.start = 1'b0; bus.abort = 1'b0;
        bus.cmd_snt = 1'b0; bus.resp_rdy = 1'b0; bus.resp = '0;

        vecs[0] = mk(2, {16'h0, 16'h0, 16'h23F1, 16'h0000}, 8'b00_00_00_00,
                     {8'h00, 8'h00, 8'hA5, 8'hA5}, 2, 0, 0, 0, 2);
        vecs[3] = mk(1, {16'h0, 16'h0, 16'h0, 16'h5555}, 8'b00_00_00_10,
                     {8'h00, 8'h00, 8'h00, 8'hA5}, 1, 0, 0, 0, 1);
`ifdef SEQ_STOP_ON_FAIL_EN
        vecs[1] = mk(3, {16'h0, 16'h3333, 16'h2222, 16'h1111}, 8'b00_00_00_00,
                     {8'h00, 8'hA5, 8'h5A, 8'hA5}, 1, 1, 1, 0, 2);
        vecs[2] = mk(2, {16'h0, 16'h0, 16'h0F0F, 16'hABCD}, 8'b00_00_00_01,
                     {8'h00, 8'h00, 8'hA5, 8'h00}, 0, 1, 0, 1, 1);
        vecs[4] = mk(4, {16'h8000, 16'h0001, 16'hBEEF, 16'hDEAD}, 8'b00_00_00_00,
                     {8'hFF, 8'h00, 8'hA5, 8'hA5}, 2, 1, 2, 0, 3);
`else
        vecs[1] = mk(3, {16'h0, 16'h3333, 16'h2222, 16'h1111}, 8'b00_00_00_00,
                     {8'h00, 8'hA5, 8'h5A, 8'hA5}, 2, 1, 1, 0, 3);
        vecs[2] = mk(2, {16'h0, 16'h0, 16'h0F0F, 16'hABCD}, 8'b00_00_00_01,
                     {8'h00, 8'h00, 8'hA5, 8'h00}, 1, 1, 0, 1, 2);
        vecs[4] = mk(4, {16'h8000, 16'h0001, 16'hBEEF, 16'hDEAD}, 8'b00_00_00_00,
                     {8'hFF, 8'h00, 8'hA5, 8'hA5}, 2, 2, 2, 0, 4);
`endif

        step();
        step();
        check_reset_outputs("por");
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vecs[v].n; i++) load(vecs[v].c[i]);
            check("full_load", 32'(bus.full), (vecs[v].n == DEPTH) ? 32'd1 : 32'd0);
            start_run();
            iss = 0;
            for (int i = 0; i < vecs[v].n; i++) begin
                wait_event(got);
                if (!got) break;
                check("cmd_word", 32'(bus.cmd), 32'(vecs[v].c[i]));
                $display("vec %0d cmd %0d: word 0x%04h mode %0d resp 0x%02h",
                         v, i, bus.cmd, vecs[v].mode[i], vecs[v].r[i]);
                iss++;
                respond(vecs[v].mode[i], vecs[v].r[i]);
            end
            wait_done();
            check("issued", 32'(iss), 32'(vecs[v].e_iss));
            check("pass_cnt", 32'(bus.pass_cnt), 32'(vecs[v].e_pass));
            check("fail_cnt", 32'(bus.fail_cnt), 32'(vecs[v].e_fail));
            check("fail_idx", 32'(bus.fail_idx), 32'(vecs[v].e_idx));
            check("tmo", 32'(bus.tmo), 32'(vecs[v].e_tmo));
            check("busy_done", 32'(bus.busy), 32'd0);
        end

        // Full queue drops the extra entry; loads while busy are ignored.
        for (int i = 0; i < DEPTH; i++) load(16'hA000 + 16'(i));
        check("full_set", 32'(bus.full), 32'd1);
        load(16'hA0FF);
        check("full_hold", 32'(bus.full), 32'd1);
        start_run();
        bus.ld_data = 16'hB0B0;
        iss = 0;
        for (int i = 0; i < DEPTH; i++) begin
            wait_event(got);
            if (!got) break;
            check("fill_cmd", 32'(bus.cmd), 32'(16'hA000 + 16'(i)));
            $display("fill cmd %0d: word 0x%04h", i, bus.cmd);
            iss++;
            bus.ld_cmd = (i == 0);
            respond(2'd0, 8'hA5);
            bus.ld_cmd = 1'b0;
        end
        wait_done();
        check("fill_issued", 32'(iss), 32'(DEPTH));
        check("fill_pass", 32'(bus.pass_cnt), 32'(DEPTH));
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("busy_drop_done", 32'(bus.done), 32'd1);
        check("busy_drop_busy", 32'(bus.busy), 32'd0);

        // Abort while waiting for a response.
        load(16'hC001);
        load(16'hC002);
        start_run();
        respond(2'd0, 8'hA5);
        wait_event(got);
        check("abort_cmd", 32'(bus.cmd), 32'hC002);
        step();
        bus.cmd_snt = 1'b1;
        step();
        bus.cmd_snt = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        $display("abort issued in WAIT_RESP");
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_pass_kept", 32'(bus.pass_cnt), 32'd1);
        for (int k = 0; k < 10; k++) begin
            check("abort_no_snd", 32'(bus.snd_cmd), 32'd0);
            step();
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("abort_empty_done", 32'(bus.done), 32'd1);
        check("abort_empty_busy", 32'(bus.busy), 32'd0);
        check("abort_empty_pass", 32'(bus.pass_cnt), 32'd0);

        // Reset mid-run, in the cycle a send strobe is up.
        load(16'hD001);
        load(16'hD002);
        start_run();
        respond(2'd0, 8'hA5);
        wait_event(got);
        check("rst_pre_pass", 32'(bus.pass_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        $display("reset asserted mid-run");
        check_reset_outputs("midrst");
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("post_rst_snd", 32'(bus.snd_cmd), 32'd0);
            check("post_rst_busy", 32'(bus.busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
